fsm_fetch: RTL and testbench

FSM_FETCH -- requirements
Module: fsm_fetch

---
 rtl/fsm_fetch_pkg.sv | 34 +++
 rtl/fsm_prog_mem.sv | 26 ++
 rtl/fsm_fetch.sv | 115 +++++++++++
 tb/tb_fsm_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_fetch_pkg.sv
// Shared definitions for the fetch and decode stages: SIZE-derived widths,
// the HALT instruction word and the fetch FSM state encoding.
package fsm_fetch_pkg;

    localparam int unsigned DefaultSize = 4;

    // Field widths derived from the datapath size; the decode stage uses the same split.
    function automatic int unsigned opcode_width(input int unsigned size);
        return size - 1;
    endfunction

    function automatic int unsigned operand_width(input int unsigned size);
        return size - 2;
    endfunction

    // Instruction word is {opcode, operand1, operand2}.
    function automatic int unsigned word_width(input int unsigned size);
        return 2 * size - 1;
    endfunction

    localparam int unsigned OpcodeW  = opcode_width(DefaultSize);
    localparam int unsigned OperandW = operand_width(DefaultSize);
    localparam int unsigned WordW    = word_width(DefaultSize);

    // An all-ones word terminates the program and is never issued.
    localparam logic [WordW-1:0] HaltWord = '1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fsm_prog_mem.sv
// Program storage: synchronous write, combinational read, no reset so the
// program survives a fetch-stage reset.
module fsm_prog_mem #(
    parameter int unsigned Width = 7,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Write port; contents are intentionally left untouched by any reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fsm_fetch.sv
// Instruction fetch stage: walks program memory from address 0 on start,
// issuing one registered instruction per unstalled cycle until a HALT word
// or the last address is reached.
module fsm_fetch
    import fsm_fetch_pkg::*;
#(
    parameter int unsigned SIZE     = DefaultSize,
    parameter int unsigned PROG_LEN = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              stall,
    input  logic                              prog_we,
    input  logic [$clog2(PROG_LEN)-1:0]       prog_addr,
    input  logic [word_width(SIZE)-1:0]       prog_data,
    output logic [opcode_width(SIZE)-1:0]     opcode,
    output logic [operand_width(SIZE)-1:0]    operand1,
    output logic [operand_width(SIZE)-1:0]    operand2,
    output logic                              instr_valid,
    output logic [$clog2(PROG_LEN)-1:0]       pc,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned OpW   = opcode_width(SIZE);
    localparam int unsigned OprW  = operand_width(SIZE);
    localparam int unsigned WrdW  = word_width(SIZE);
    localparam int unsigned AddrW = $clog2(PROG_LEN);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(PROG_LEN - 1);
    localparam logic [WrdW-1:0]  HaltW    = {WrdW{1'b1}};

    fetch_state_e      state_q;
    logic [AddrW-1:0]  pc_q;
    logic [OpW-1:0]    opcode_q;
    logic [OprW-1:0]   operand1_q;
    logic [OprW-1:0]   operand2_q;
    logic              instr_valid_q;
    logic [WrdW-1:0]   fetch_word;
    logic              mem_we;

    // The program may only be rewritten while the fetch is not walking it.
    assign mem_we = prog_we && !rst && (state_q != StRun);

    fsm_prog_mem #(
        .Width (WrdW),
        .Depth (PROG_LEN)
    ) u_prog_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (fetch_word)
    );

    // Fetch FSM with registered instruction outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            opcode_q      <= '0;
            operand1_q    <= '0;
            operand2_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StHalt: begin
                    // Outputs drop to zero the cycle after the last issue.
                    opcode_q      <= '0;
                    operand1_q    <= '0;
                    operand2_q    <= '0;
                    instr_valid_q <= 1'b0;
                    if (start) begin
                        state_q <= StRun;
                        pc_q    <= '0;
                    end
                end
                StRun: begin
                    if (!stall) begin
                        if (fetch_word == HaltW) begin
                            // pc stays on the HALT word's address.
                            opcode_q      <= '0;
                            operand1_q    <= '0;
                            operand2_q    <= '0;
                            instr_valid_q <= 1'b0;
                            state_q       <= StHalt;
                        end else begin
                            {opcode_q, operand1_q, operand2_q} <= fetch_word;
                            instr_valid_q <= 1'b1;
                            if (pc_q == LastAddr) begin
                                state_q <= StHalt;
                            end else begin
                                pc_q <= pc_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign opcode      = opcode_q;
    assign operand1    = operand1_q;
    assign operand2    = operand2_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StHalt);

endmodule

// File: tb/tb_fsm_fetch.sv
// Directed self-checking bench for fsm_fetch at SIZE=4, PROG_LEN=16.
module tb_fsm_fetch;

    localparam int unsigned SIZE     = 4;
    localparam int unsigned PROG_LEN = 16;

    localparam logic [6:0] W0    = 7'b001_01_10;
    localparam logic [6:0] W1    = 7'b010_11_00;
    localparam logic [6:0] W2    = 7'b011_00_01;
    localparam logic [6:0] WHalt = 7'b111_11_11;
    localparam logic [6:0] WNew  = 7'b100_10_11;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stall;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [6:0] prog_data;
    logic [2:0] opcode;
    logic [1:0] operand1;
    logic [1:0] operand2;
    logic       instr_valid;
    logic [3:0] pc;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    fsm_fetch #(
        .SIZE     (SIZE),
        .PROG_LEN (PROG_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .opcode      (opcode),
        .operand1    (operand1),
        .operand2    (operand2),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [6:0] w,
                              input logic [3:0] p, input logic b, input logic d);
        chk({tag, " valid"}, 32'(instr_valid), 32'(v));
        chk({tag, " word"}, 32'({opcode, operand1, operand2}), 32'(w));
        chk({tag, " pc"}, 32'(pc), 32'(p));
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(d));
    endtask

    task automatic write_word(input logic [3:0] a, input logic [6:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stall     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        tick();
        tick();
        rst = 1'b0;
        expect_out("reset", 1'b0, 7'h00, 4'd0, 1'b0, 1'b0);

        // Basic program: three issues then HALT at address 3.
        write_word(4'd0, W0);
        write_word(4'd1, W1);
        write_word(4'd2, W2);
        write_word(4'd3, WHalt);
        expect_out("idle after load", 1'b0, 7'h00, 4'd0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t1 start", 1'b0, 7'h00, 4'd0, 1'b1, 1'b0);
        tick();
        expect_out("t1 i0", 1'b1, W0, 4'd1, 1'b1, 1'b0);
        tick();
        expect_out("t1 i1", 1'b1, W1, 4'd2, 1'b1, 1'b0);
        tick();
        expect_out("t1 i2", 1'b1, W2, 4'd3, 1'b1, 1'b0);
        tick();
        expect_out("t1 halt", 1'b0, 7'h00, 4'd3, 1'b0, 1'b1);

        // Stall after the second issue; start held in RUN must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t2 start", 1'b0, 7'h00, 4'd0, 1'b1, 1'b0);
        tick();
        expect_out("t2 i0", 1'b1, W0, 4'd1, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t2 i1 start ignored", 1'b1, W1, 4'd2, 1'b1, 1'b0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out($sformatf("t2 stall%0d", k), 1'b1, W1, 4'd2, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick();
        expect_out("t2 i2", 1'b1, W2, 4'd3, 1'b1, 1'b0);
        tick();
        expect_out("t2 halt", 1'b0, 7'h00, 4'd3, 1'b0, 1'b1);

        // stall has no effect in HALT, so start still enters RUN.
        stall = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t3 start under stall", 1'b0, 7'h00, 4'd0, 1'b1, 1'b0);
        tick();
        expect_out("t3 stalled run", 1'b0, 7'h00, 4'd0, 1'b1, 1'b0);
        stall = 1'b0;

        // Writes during RUN must be dropped.
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 7'h55;
        tick();
        expect_out("t3 i0", 1'b1, W0, 4'd1, 1'b1, 1'b0);
        tick();
        expect_out("t3 i1 we ignored", 1'b1, W1, 4'd2, 1'b1, 1'b0);
        tick();
        expect_out("t3 i2", 1'b1, W2, 4'd3, 1'b1, 1'b0);
        tick();
        prog_we = 1'b0;
        expect_out("t3 halt", 1'b0, 7'h00, 4'd3, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_out("t3 rerun i0", 1'b1, W0, 4'd1, 1'b1, 1'b0);
        tick();
        expect_out("t3 rerun i1", 1'b1, W1, 4'd2, 1'b1, 1'b0);
        tick();
        tick();
        expect_out("t3 rerun halt", 1'b0, 7'h00, 4'd3, 1'b0, 1'b1);

        // Reset mid-RUN under stall, then rerun the retained program.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_out("t4 i0", 1'b1, W0, 4'd1, 1'b1, 1'b0);
        stall = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        expect_out("t4 reset", 1'b0, 7'h00, 4'd0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t4 restart", 1'b0, 7'h00, 4'd0, 1'b1, 1'b0);
        tick();
        expect_out("t4 i0", 1'b1, W0, 4'd1, 1'b1, 1'b0);
        tick();
        expect_out("t4 i1", 1'b1, W1, 4'd2, 1'b1, 1'b0);
        tick();
        expect_out("t4 i2", 1'b1, W2, 4'd3, 1'b1, 1'b0);
        tick();
        expect_out("t4 halt", 1'b0, 7'h00, 4'd3, 1'b0, 1'b1);

        // start and a write to address 0 together in IDLE.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("t5 idle", 1'b0, 7'h00, 4'd0, 1'b0, 1'b0);
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = WNew;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        expect_out("t5 start", 1'b0, 7'h00, 4'd0, 1'b1, 1'b0);
        tick();
        expect_out("t5 i0 new word", 1'b1, WNew, 4'd1, 1'b1, 1'b0);
        tick();
        expect_out("t5 i1", 1'b1, W1, 4'd2, 1'b1, 1'b0);
        tick();
        tick();
        expect_out("t5 halt", 1'b0, 7'h00, 4'd3, 1'b0, 1'b1);

        // Full memory of non-HALT words: 16 issues, HALT at the end, no wrap.
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), 7'(i * 3 + 1));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t6 start", 1'b0, 7'h00, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_out($sformatf("t6 i%0d", i), 1'b1, 7'(i * 3 + 1),
                       (i == 15) ? 4'd15 : 4'(i + 1), (i != 15), (i == 15));
        end
        tick();
        expect_out("t6 halt", 1'b0, 7'h00, 4'd15, 1'b0, 1'b1);
        tick();
        expect_out("t6 no wrap", 1'b0, 7'h00, 4'd15, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
